// File: rtl/xw_dot_seq.sv
// Bit-serial dot product sequencer: streams N bit pairs from x/w memories and accumulates them.
// Latency: result_valid N+1 cycles after accepted start (length 0 -> 1 cycle), plus hold cycles.
// Backpressure: hold stalls FETCH in place; DONE holds result until result_ready handshake.
// Optional feature macro: XW_BIPOLAR_EN (XNOR +1/-1 signed accumulate instead of AND count).
module xw_dot_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  x_bank,
    input  logic [1:0]  w_bank,
    input  logic [9:0]  x_base,
    input  logic [19:0] w_base,
    input  logic [10:0] length,
    input  logic        hold,
    output logic [1:0]  sel_x,
    output logic [1:0]  sel_w,
    output logic [9:0]  rw_address_x,
    output logic [19:0] rw_address,
    output logic        read_rq_x,
    output logic        read_rq_w,
    output logic        write_rq_x,
    output logic        write_rq_w,
    input  logic        read_data_x,
    input  logic        read_data_w,
    output logic        busy,
    output logic [11:0] result,
    output logic        result_valid,
    input  logic        result_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        step;
    logic [10:0] len_clamped;
    logic [10:0] count;
    logic [11:0] acc;
    logic [11:0] inc;
    logic        bit_x;
    logic        bit_w;

    // Anything other than a clean 1 (including z/x from the memory) counts as 0.
    assign bit_x = (read_data_x === 1'b1);
    assign bit_w = (read_data_w === 1'b1);

    assign len_clamped = (length > 11'd1024) ? 11'd1024 : length;
    assign step        = (state == FETCH) && !hold;

`ifdef XW_BIPOLAR_EN
    assign inc = (bit_x == bit_w) ? 12'd1 : 12'hFFF;
`else
    assign inc = {11'd0, bit_x & bit_w};
`endif

    assign read_rq_x    = (state == FETCH);
    assign read_rq_w    = (state == FETCH);
    assign write_rq_x   = 1'b0;
    assign write_rq_w   = 1'b0;
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result       = acc;

    // State register; reset abandons any run immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a start coinciding with the DONE handshake is not seen until IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !result_valid) begin
                    accept    = 1'b1;
                    state_nxt = (len_clamped == 11'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (step && (count == 11'd1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the job on accept, then advance addresses and accumulate per unstalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_x        <= 2'd0;
            sel_w        <= 2'd0;
            rw_address_x <= 10'd0;
            rw_address   <= 20'd0;
            count        <= 11'd0;
            acc          <= 12'd0;
        end else if (accept) begin
            sel_x        <= x_bank;
            sel_w        <= w_bank;
            rw_address_x <= x_base;
            rw_address   <= w_base;
            count        <= len_clamped;
            acc          <= 12'd0;
        end else if (step) begin
            // Both addresses wrap naturally at their field width.
            rw_address_x <= rw_address_x + 10'd1;
            rw_address   <= rw_address + 20'd1;
            count        <= count - 11'd1;
            acc          <= acc + inc;
        end
    end

endmodule

// File: doc/xw_dot_seq.md
XW_DOT_SEQ -- requirements
Module: xw_dot_seq

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  launch request, sampled in IDLE only.
REQ-004 SHALL have port x_bank  input  2  x memory bank select, latched on accepted start.
REQ-005 SHALL have port w_bank  input  2  w memory bank select, latched on accepted start.
REQ-006 SHALL have port x_base  input  10  first x bit address, latched on accepted start.
REQ-007 SHALL have port w_base  input  20  first w bit address, latched on accepted start.
REQ-008 SHALL have port length  input  11  bit pairs to process, latched on accepted start.
REQ-009 SHALL have port hold  input  1  stall; while high in FETCH, no address advance and no accumulation.
REQ-010 SHALL have ports sel_x/sel_w  output  2 each  bank selects to the memory system.
REQ-011 SHALL have ports rw_address_x  output  10 and rw_address  output  20  bit addresses to the memory system.
REQ-012 SHALL have ports read_rq_x, read_rq_w, write_rq_x, write_rq_w  output  1 each  memory requests; write_rq_* SHALL be tied 0.
REQ-013 SHALL have ports read_data_x, read_data_w  input  1 each  bit returned by the memory system in the same cycle as the address.
REQ-014 SHALL have ports busy  output  1, result  output  12, result_valid  output  1, result_ready  input  1.

Function
REQ-015 SHALL implement states IDLE, FETCH, DONE; start in IDLE accepted when result_valid is low.
REQ-016 Accepted start with length 0 SHALL go IDLE->DONE, result 0; length 1..1024 SHALL go IDLE->FETCH; length >1024 SHALL clamp to 1024.
REQ-017 In FETCH, read_rq_x and read_rq_w SHALL be 1, addresses and selects registered; elsewhere read_rq_* SHALL be 0.
REQ-018 Each FETCH cycle with hold low SHALL accumulate the pair (read_data_x, read_data_w) and advance both addresses by 1 at the clock edge.
REQ-019 x address SHALL wrap 1023->0; w address SHALL wrap 0xFFFFF->0.
REQ-020 Read data of value z/x SHALL be treated as 0.
REQ-021 FETCH SHALL last exactly N unstalled cycles (N = clamped length), then enter DONE; latency start->result_valid = N+1 cycles plus hold cycles.
REQ-022 In DONE, result_valid SHALL be 1 and result stable until result_valid and result_ready both high; then IDLE next cycle.
REQ-023 busy SHALL be 1 in FETCH and DONE.
REQ-024 start in FETCH or DONE SHALL be ignored; start and handshake completion in the same cycle SHALL NOT launch (start must be re-asserted in IDLE).

Reset
REQ-025 rst low SHALL force IDLE immediately, any operation abandoned.
REQ-026 Reset values: busy 0, result 0, result_valid 0, read_rq_* 0, write_rq_* 0, sel_x/sel_w 0, addresses 0.

Configuration
REQ-027 Macro XW_BIPOLAR_EN defined: each pair adds +1 if bits equal (XNOR) else -1; result two's-complement signed, range -1024..1024.
REQ-028 XW_BIPOLAR_EN undefined: each pair adds x AND w; result unsigned, range 0..1024.

Verification
REQ-029 x bank 1 = 16 ones from 0, w bank 2 = 16 ones from 0x100; start length 16, x_base 0, w_base 0x100 -> result 16 both modes, result_valid on cycle 17.
REQ-030 x alternating 1010..., w all 1, length 8, bipolar -> result 0; unsigned -> result 4.
REQ-031 x_base 1022, w_base 0xFFFFF, length 4 -> x addresses 1022,1023,0,1; w addresses 0xFFFFF,0,1,2.
REQ-032 length 2000 -> exactly 1024 FETCH cycles; length 0 -> result_valid next cycle, result 0, no read_rq.
REQ-033 hold high 3 cycles mid-run and result_ready low 5 cycles in DONE -> result unchanged, latency extended by 3, result stable while waiting.
REQ-034 rst low mid-FETCH -> all outputs at reset values in same cycle; new start after release runs normally.
